// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// leading-zero blanking and overflow flag, feeding per-digit 7-seg decoders.
// Optional feature macro: LEADING_ZERO_BLANK_EN (undefined: only the digits
// are shown, with no leading-zero blanking after the first conversion).
module bin_to_bcd_display #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_acc;
    logic               r_ovf_acc;
    logic [CNT_W-1:0]   r_count;

    logic [BCD_W-1:0]   r_bcd;
    logic [DIGITS-1:0]  r_blank;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_acc_next;
    logic               w_ovf_next;
    logic [DIGITS-1:0]  w_blank_next;

    // State register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and accept/last-iteration strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_count == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Add-3 correction, one-bit shift, and sticky capture of the dropped carry
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
        w_acc_next = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
        w_ovf_next = r_ovf_acc | w_adj[BCD_W-1];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank digit i when it and every more-significant digit are zero; digit 0 always shown
    always_comb begin
        logic w_zero;
        w_zero       = 1'b1;
        w_blank_next = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_zero          = w_zero & (w_acc_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = w_zero;
        end
    end
`else
    // All digits lit once a conversion has completed
    always_comb begin
        w_blank_next = '0;
    end
`endif

    // Datapath: shift iterations plus output registers loaded only on completion
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_shift    <= '0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_count    <= '0;
            r_bcd      <= '0;
            r_blank    <= '1;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_shift   <= bin;
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
                r_count   <= CNT_W'(WIDTH);
                r_busy    <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                r_acc     <= w_acc_next;
                r_ovf_acc <= w_ovf_next;
                r_count   <= r_count - CNT_W'(1);
                if (w_last) begin
                    r_bcd      <= w_acc_next;
                    r_blank    <= w_blank_next;
                    r_overflow <= w_ovf_next;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign blank    = r_blank;
    assign overflow = r_overflow;

endmodule
